// File: rtl/long_sync_ctrl.sv
// -----------------------------------------------------------------------------
// long_sync_ctrl
//
// Control FSM for the long-preamble synchronization stage. It drives an
// external registered load/done sample counter and turns the coarse-timing
// Start pulse and the fine-correlation Peak into a per-sample FFT window
// strobe: GI_LEN guard samples skipped, then FFT_LEN windowed samples,
// repeating until Frame_End.
//
// Parameters
//   CNT_W       width of counter values and of the counter's init/final buses
//   SEARCH_LEN  valid samples allowed for the peak search before failing
//   GI_LEN      guard-interval samples skipped per symbol (>= 2)
//   FFT_LEN     window samples per symbol (>= 2)
//
// Ports
//   CLK        in   clock
//   s_RST_n    in   synchronous active-low reset
//   Start      in   one-cycle coarse-timing pulse, honoured only in IDLE
//   In_Valid   in   input-sample strobe
//   Peak       in   fine-correlation peak, qualified by In_Valid
//   Frame_End  in   frame abort/end pulse, returns to IDLE from any state
//   Cnt_Done   in   counter Done (value == final)
//   Cnt_Load   out  counter Load (never together with Cnt_Count)
//   Cnt_Count  out  counter Count
//   Cnt_Up     out  counter direction, always up
//   Cnt_Init   out  counter initial value, 0 when Cnt_Load is low
//   Cnt_Final  out  counter final value, 0 when Cnt_Load is low
//   Win_Valid  out  current sample belongs to the FFT window
//   Sym_Start  out  first window sample of a symbol
//   Locked     out  high in GI and SYM
//   Sync_Fail  out  one-cycle pulse after a search timeout
//   Sym_Idx    out  completed symbols, saturating at 255
// -----------------------------------------------------------------------------
module long_sync_ctrl #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned SEARCH_LEN = 200,
    parameter int unsigned GI_LEN     = 16,
    parameter int unsigned FFT_LEN    = 64
) (
    input  logic             CLK,
    input  logic             s_RST_n,
    input  logic             Start,
    input  logic             In_Valid,
    input  logic             Peak,
    input  logic             Frame_End,
    input  logic             Cnt_Done,
    output logic             Cnt_Load,
    output logic             Cnt_Count,
    output logic             Cnt_Up,
    output logic [CNT_W-1:0] Cnt_Init,
    output logic [CNT_W-1:0] Cnt_Final,
    output logic             Win_Valid,
    output logic             Sym_Start,
    output logic             Locked,
    output logic             Sync_Fail,
    output logic [7:0]       Sym_Idx
);

    localparam logic [CNT_W-1:0] SrchFinal = CNT_W'(SEARCH_LEN);
    localparam logic [CNT_W-1:0] GiFinal   = CNT_W'(GI_LEN);
    localparam logic [CNT_W-1:0] FftFinal  = CNT_W'(FFT_LEN);

    typedef enum logic [1:0] {
        StIdle,
        StSrch,
        StGi,
        StSym
    } state_e;

    // Registered state
    state_e     r_state;
    logic       r_sync_fail;
    logic [7:0] r_sym_idx;
    logic       r_first;

    // Next-state values
    state_e     w_state_nxt;
    logic       w_sync_fail_nxt;
    logic [7:0] w_sym_idx_nxt;
    logic       w_first_nxt;

    // Decoded transition events
    logic w_search_go;
    logic w_srch_timeout;
    logic w_gi_to_sym;
    logic w_sym_to_gi;

    // Unqualified combinational outputs, gated by reset below
    logic             w_load;
    logic             w_count;
    logic [CNT_W-1:0] w_init;
    logic [CNT_W-1:0] w_final;
    logic             w_win;

    // Sample on the current cycle, zero-extended to the counter width.
    // A reload cycle that carries a sample counts it via the initial value.
    logic [CNT_W-1:0] w_valid_ext;
    assign w_valid_ext = {{(CNT_W-1){1'b0}}, In_Valid};

    // -------------------------------------------------------------------------
    // Transition events. Frame_End outranks everything outside IDLE, and a
    // search timeout (Done) outranks a simultaneous Peak.
    // -------------------------------------------------------------------------
    always_comb begin
        w_search_go    = 1'b0;
        w_srch_timeout = 1'b0;
        w_gi_to_sym    = 1'b0;
        w_sym_to_gi    = 1'b0;
        case (r_state)
            StIdle: w_search_go    = Start;
            StSrch: w_srch_timeout = !Frame_End && Cnt_Done;
            StGi:   w_gi_to_sym    = !Frame_End && Cnt_Done;
            StSym:  w_sym_to_gi    = !Frame_End && Cnt_Done;
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!s_RST_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: begin
                if (Start) begin
                    w_state_nxt = StSrch;
                end
            end
            StSrch: begin
                if (Frame_End || Cnt_Done) begin
                    w_state_nxt = StIdle;
                end else if (Peak && In_Valid) begin
                    w_state_nxt = StGi;
                end
            end
            StGi: begin
                if (Frame_End) begin
                    w_state_nxt = StIdle;
                end else if (Cnt_Done) begin
                    w_state_nxt = StSym;
                end
            end
            StSym: begin
                if (Frame_End) begin
                    w_state_nxt = StIdle;
                end else if (Cnt_Done) begin
                    w_state_nxt = StGi;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // -------------------------------------------------------------------------
    // Mealy outputs. Each counter load is issued in the transition cycle, so
    // the counter holds the new range from the following cycle onward.
    // -------------------------------------------------------------------------
    always_comb begin
        w_load  = 1'b0;
        w_count = 1'b0;
        w_init  = '0;
        w_final = '0;
        w_win   = 1'b0;
        case (r_state)
            StIdle: begin
                if (Start) begin
                    w_load  = 1'b1;
                    w_final = SrchFinal;
                end
            end
            StSrch: begin
                if (Frame_End || Cnt_Done) begin
                    w_count = 1'b0;
                end else if (Peak && In_Valid) begin
                    // The peak sample closes the training symbol; not counted.
                    w_load  = 1'b1;
                    w_final = GiFinal;
                end else begin
                    w_count = In_Valid;
                end
            end
            StGi: begin
                if (Frame_End) begin
                    w_count = 1'b0;
                end else if (Cnt_Done) begin
                    w_load  = 1'b1;
                    w_init  = w_valid_ext;
                    w_final = FftFinal;
                    w_win   = In_Valid;
                end else begin
                    w_count = In_Valid;
                end
            end
            StSym: begin
                if (Frame_End) begin
                    w_count = 1'b0;
                end else if (Cnt_Done) begin
                    // A sample on this cycle is the first guard sample.
                    w_load  = 1'b1;
                    w_init  = w_valid_ext;
                    w_final = GiFinal;
                end else begin
                    w_count = In_Valid;
                    w_win   = In_Valid;
                end
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Auxiliary registers: fail pulse, symbol index, first-sample flag
    // -------------------------------------------------------------------------
    always_comb begin
        w_sync_fail_nxt = w_srch_timeout;

        w_sym_idx_nxt = r_sym_idx;
        if (w_search_go) begin
            w_sym_idx_nxt = 8'd0;
        end else if (w_sym_to_gi && (r_sym_idx != 8'hFF)) begin
            w_sym_idx_nxt = r_sym_idx + 8'd1;
        end

        // When the load cycle itself carries a sample, Sym_Start fires right
        // away and the flag never needs to be held.
        w_first_nxt = r_first;
        if (w_gi_to_sym) begin
            w_first_nxt = !In_Valid;
        end else if (w_win || Frame_End) begin
            w_first_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!s_RST_n) begin
            r_sync_fail <= 1'b0;
            r_sym_idx   <= 8'd0;
            r_first     <= 1'b0;
        end else begin
            r_sync_fail <= w_sync_fail_nxt;
            r_sym_idx   <= w_sym_idx_nxt;
            r_first     <= w_first_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Output drive. Outputs are forced to zero while reset is asserted, even
    // before the first clock edge has cleared the registers.
    // -------------------------------------------------------------------------
    assign Cnt_Up    = 1'b1;
    assign Cnt_Load  = s_RST_n & w_load;
    assign Cnt_Count = s_RST_n & w_count;
    assign Cnt_Init  = s_RST_n ? w_init : '0;
    assign Cnt_Final = s_RST_n ? w_final : '0;
    assign Win_Valid = s_RST_n & w_win;
    assign Sym_Start = s_RST_n & w_win & (r_first | w_gi_to_sym);
    assign Locked    = s_RST_n & ((r_state == StGi) || (r_state == StSym));
    assign Sync_Fail = s_RST_n & r_sync_fail;
    assign Sym_Idx   = s_RST_n ? r_sym_idx : 8'd0;

endmodule

// File: doc/long_sync_ctrl.md
# long_sync_ctrl

Control FSM for the long-preamble synchronization stage. It sits directly upstream of the stage's load/done sample counter and drives that counter's `Load`, `Count`, `C_up`, initial-value and final-value inputs, and consumes its `Done` flag. It turns the coarse-timing start pulse and the fine cross-correlation peak into a per-sample FFT window strobe: 64 payload samples per symbol, with the cyclic prefix skipped. The downstream FFT uses that strobe.

## Interface
- CNT_W, 8, width of counter values and of the counter's initial/final buses
- SEARCH_LEN, 200, valid samples allowed for peak search before failing
- GI_LEN, 16, guard-interval samples to skip per symbol (≥2)
- FFT_LEN, 64, window samples per symbol (≥2)

- CLK  in  1  clock
- s_RST_n  in  1  synchronous, active-low reset. The counter instance receives ~s_RST_n on its own reset.
- Start  in  1  one-cycle coarse-timing pulse from the short-sync stage
- In_Valid  in  1  input-sample strobe
- Peak  in  1  fine-correlation peak. Meaningful only with In_Valid. Marks the last sample of the second long training symbol.
- Frame_End  in  1  frame abort/end pulse from the decoder
- Cnt_Done  in  1  counter Done
- Cnt_Load  out  1  counter Load
- Cnt_Count  out  1  counter Count
- Cnt_Up  out  1  counter C_up, tied to 1
- Cnt_Init  out  CNT_W  counter initial value
- Cnt_Final  out  CNT_W  counter final value
- Win_Valid  out  1  current sample is an FFT window sample
- Sym_Start  out  1  first window sample of a symbol
- Locked  out  1  high in GI and SYM
- Sync_Fail  out  1  one-cycle pulse on search timeout
- Sym_Idx  out  8  number of completed symbols, saturating at 255

## Operation
- Counter contract:
  - The counter is registered.
  - It increments when Count & !Done.
  - Otherwise, if Load is asserted, it loads Init and Final.
  - Done is (value == Final).
  - Because Count has priority over Load, this block never asserts Cnt_Load and Cnt_Count together.
- States are IDLE, SRCH, GI and SYM. There are no separate load states: each load is issued as a Mealy output in the cycle of the transition.
- IDLE:
  - Start=1 → Load(Init=0, Final=SEARCH_LEN), go to SRCH.
  - Otherwise Count=0 and Load=0.
- SRCH:
  - Default: Count=In_Valid.
  - Cnt_Done=1 → Count=0, go to IDLE, Sync_Fail=1 next cycle. Done wins over a simultaneous Peak.
  - Else if Peak&In_Valid → Count=0, Load(Init=0, Final=GI_LEN), go to GI. The peak sample itself is not counted.
- GI:
  - Default: Count=In_Valid, Win_Valid=0.
  - Cnt_Done=1 → Count=0, Load(Init={0,In_Valid}, Final=FFT_LEN), go to SYM.
  - On that load cycle, Win_Valid=In_Valid. A sample that arrives on the load cycle is both counted and windowed.
- SYM:
  - Default: Count=In_Valid, Win_Valid=In_Valid.
  - Cnt_Done=1 → Count=0, Win_Valid=0, Load(Init={0,In_Valid}, Final=GI_LEN), go to GI, Sym_Idx+1 (saturating).
- Sym_Start = Win_Valid for the first windowed sample after each GI→SYM transition. It is tracked by an internal first-sample flag, which is set on the GI→SYM load and cleared on the first Win_Valid.
- Frame_End in any state except IDLE → IDLE next cycle, with Load=0 and Count=0 that cycle. Frame_End overrides every other transition. Sym_Idx is cleared on the next Start.
- Start while not in IDLE is ignored.
- Cnt_Load, Cnt_Count, Cnt_Init, Cnt_Final, Win_Valid and Sym_Start are combinational from state and inputs. Cnt_Init and Cnt_Final are 0 when Cnt_Load=0.
- State, Sync_Fail, Sym_Idx and the first-sample flag are registered.

## Timing
- While s_RST_n=0, all outputs are forced low/zero except Cnt_Up=1: state IDLE, Sym_Idx=0, Sync_Fail=0, Locked=0, first-sample flag 0.
- Zero-latency Mealy control: Win_Valid is aligned to the same cycle as In_Valid.
- Counter Done rises one cycle after the final counted sample. That cycle is the reload cycle, so with continuous In_Valid no sample is lost or duplicated:
  - GI_LEN skipped samples, then FFT_LEN windowed samples, repeating.
- Search timeout: the Done cycle t in SRCH gives Sync_Fail=1 at t+1 for exactly one cycle, with the state in IDLE.
- Stale Done from a previous run is harmless: it is never sampled in IDLE, and each load's effect is visible from the next cycle.

## Test plan
- Reset: hold s_RST_n=0 for 3 cycles with Start=1 → Cnt_Load=0, Cnt_Count=0, Locked=0, Sym_Idx=0, Sync_Fail=0; after release the state is IDLE.
- Timeout: Start, then 200 continuous valid samples with no Peak → Sync_Fail high for exactly 1 cycle, Locked never high; a following Start restarts the search.
- Continuous lock: Start, Peak on valid sample 50, then continuous In_Valid → 16 cycles with Win_Valid=0, 64 with Win_Valid=1 (Sym_Start only on the first), 16 GI cycles, and Sym_Idx=1 after the first symbol, 2 after the second.
- Gapped input: In_Valid every other cycle → the same 16-skip / 64-window sample pattern, with Cnt_Init=0 on reload cycles that have no sample and 1 on those that do.
- Frame_End in the middle of a symbol → IDLE next cycle, Win_Valid=0, and Peak is ignored until a new Start.
- Peak together with Done in SRCH → Sync_Fail pulse, no transition to GI.
